ysyx_25020037_axi_rd_resp: RTL

YSYX_25020037_AXI_RD_RESP -- requirements
Module: ysyx_25020037_axi_rd_resp

---
 rtl/ysyx_25020037_axi_rd_resp_if.sv | 31 +++
 rtl/ysyx_25020037_axi_rd_resp.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020037_axi_rd_resp_if.sv
// AXI4 read channel bundle (AR + R) between an initiator
// and the ysyx_25020037 read responder.
interface ysyx_25020037_axi_rd_resp_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output arvalid, araddr, arid, arlen,
    output arsize, arburst, rready,
    input  arready, rvalid, rdata,
    input  rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen,
    input  arsize, arburst, rready,
    output arready, rvalid, rdata,
    output rresp, rlast, rid
  );
endinterface

// File: rtl/ysyx_25020037_axi_rd_resp.sv
// AXI4 read responder over a word array with fixed latency,
// FIXED/INCR/WRAP bursts, SLVERR/DECERR and a preload port.
module ysyx_25020037_axi_rd_resp #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  ysyx_25020037_axi_rd_resp_if.slave ax,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);
  localparam int          AW   = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_t;

  state_t      state;
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic [1:0]  burst_q;
  logic        err_q;
  logic [3:0]  wait_q;

  function automatic logic hit(
    input logic [31:0] a
  );
    return (a - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [AW-1:0] widx(
    input logic [31:0] a
  );
    logic [31:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  logic        hs;
  logic        err_in;
  logic        wrap_ok;
  logic [31:0] start;

  always_comb begin
    hs      = ax.arvalid & ax.arready;
    start   = ax.araddr & ~32'h3;
    wrap_ok = (ax.arlen == 8'd1) |
              (ax.arlen == 8'd3) |
              (ax.arlen == 8'd7) |
              (ax.arlen == 8'd15);
    err_in  = (ax.arsize != 3'h2) |
              (ax.arburst == 2'h3) |
              ((ax.arburst == 2'h2) & ~wrap_ok);
  end

  logic [31:0] wmask;
  logic [31:0] nxt_addr;

  // WRAP window is (len+1)*4 bytes, so its mask is len*4+3
  always_comb begin
    wmask = {22'b0, len_q, 2'b11};
    unique case (burst_q)
      2'h0:    nxt_addr = addr_q;
      2'h2:    nxt_addr = (addr_q & ~wmask) |
                          ((addr_q + 32'd4) & wmask);
      default: nxt_addr = addr_q + 32'd4;
    endcase
  end

  logic [31:0] b_addr;
  logic        b_err;
  logic [7:0]  b_idx;
  logic [7:0]  b_len;
  logic        b_hit;
  logic [31:0] b_data;
  logic [1:0]  b_resp;
  logic        b_last;

  // Beat about to be loaded into the R registers
  always_comb begin
    b_addr = nxt_addr;
    b_err  = err_q;
    b_idx  = 8'(beat_q + 8'd1);
    b_len  = len_q;
    unique case (1'b1)
      state == IDLE: begin
        b_addr = start;
        b_err  = err_in;
        b_idx  = 8'd0;
        b_len  = ax.arlen;
      end
      state == WAIT: begin
        b_addr = addr_q;
        b_idx  = 8'd0;
      end
      default: ;
    endcase
    b_hit  = hit(b_addr);
    b_data = (!b_err && b_hit) ?
             mem[widx(b_addr)] : 32'd0;
    b_resp = b_err ? 2'h2 :
             (b_hit ? 2'h0 : 2'h3);
    b_last = (b_idx == b_len);
  end

  always_ff @(posedge clk) begin
    if (ld_en && hit(ld_addr))
      mem[widx(ld_addr)] <= ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ax.arready <= 1'b0;
      ax.rvalid  <= 1'b0;
      ax.rlast   <= 1'b0;
      ax.rresp   <= 2'h0;
      ax.rid     <= 4'h0;
      ax.rdata   <= 32'd0;
      addr_q     <= 32'd0;
      len_q      <= 8'd0;
      beat_q     <= 8'd0;
      burst_q    <= 2'h0;
      err_q      <= 1'b0;
      wait_q     <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            ax.arready <= 1'b0;
            addr_q     <= start;
            len_q      <= ax.arlen;
            burst_q    <= ax.arburst;
            err_q      <= err_in;
            ax.rid     <= ax.arid;
            beat_q     <= 8'd0;
            if (LAT == 4'd0) begin
              state     <= BURST;
              ax.rvalid <= 1'b1;
              ax.rdata  <= b_data;
              ax.rresp  <= b_resp;
              ax.rlast  <= b_last;
            end else begin
              state  <= WAIT;
              wait_q <= 4'(LAT - 4'd1);
            end
          end else begin
            ax.arready <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_q == 4'd0) begin
            state     <= BURST;
            ax.rvalid <= 1'b1;
            ax.rdata  <= b_data;
            ax.rresp  <= b_resp;
            ax.rlast  <= b_last;
          end else begin
            wait_q <= 4'(wait_q - 4'd1);
          end
        end
        BURST: begin
          if (ax.rvalid && ax.rready) begin
            if (ax.rlast) begin
              state      <= IDLE;
              ax.rvalid  <= 1'b0;
              ax.rlast   <= 1'b0;
              ax.arready <= 1'b1;
            end else begin
              addr_q    <= nxt_addr;
              beat_q    <= 8'(beat_q + 8'd1);
              ax.rvalid <= 1'b1;
              ax.rdata  <= b_data;
              ax.rresp  <= b_resp;
              ax.rlast  <= b_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
